// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the RAM access arbiter.
package ram_arb_pkg;

    localparam int unsigned RAM_ARB_NREQ       = 2;
    localparam int unsigned RAM_ARB_AW         = 16;
    localparam int unsigned RAM_ARB_DW         = 16;
    localparam int unsigned RAM_ARB_ADDR_LIMIT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Width of a requester index; never zero so single-bit ports stay legal.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester-side handshake bundle plus the RAM control/data pins owned by the arbiter.
interface ram_access_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int unsigned NREQ = RAM_ARB_NREQ,
    parameter int unsigned AW   = RAM_ARB_AW,
    parameter int unsigned DW   = RAM_ARB_DW
);

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    ack;
    logic               err;
    logic [DW-1:0]      rdata;

    logic               ram_write_enable;
    logic               ram_read;
    logic [AW-1:0]      ram_access_address;
    logic [DW-1:0]      ram_write_data;
    logic [DW-1:0]      ram_data_out;

    modport slave (
        input  req, we, addr, wdata, ram_data_out,
        output ack, err, rdata,
        output ram_write_enable, ram_read, ram_access_address, ram_write_data
    );

    modport master (
        output req, we, addr, wdata, ram_data_out,
        input  ack, err, rdata,
        input  ram_write_enable, ram_read, ram_access_address, ram_write_data
    );

endinterface

// File: rtl/ram_arb_pick.sv
// Combinational winner selection: round-robin from i_ptr when RAM_ARB_RR_EN is
// defined, otherwise fixed priority with the lowest index winning.
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter  int unsigned NREQ = RAM_ARB_NREQ,
    localparam int unsigned IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
`ifdef RAM_ARB_RR_EN
    input  logic [IW-1:0]   i_ptr,
`endif
    output logic [NREQ-1:0] o_grant_c,
    output logic [IW-1:0]   o_idx_c,
    output logic            o_valid_c
);

`ifdef RAM_ARB_RR_EN
    int unsigned w_pos;

    // Walk the request vector starting at the pointer, wrapping at NREQ.
    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        w_pos     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_pos = (32'(i_ptr) + k) % NREQ;
            if (!o_valid_c && i_req[IW'(w_pos)]) begin
                o_valid_c             = 1'b1;
                o_grant_c[IW'(w_pos)] = 1'b1;
                o_idx_c               = IW'(w_pos);
            end
        end
    end
`else
    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!o_valid_c && i_req[IW'(k)]) begin
                o_valid_c         = 1'b1;
                o_grant_c[IW'(k)] = 1'b1;
                o_idx_c           = IW'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/ram_access_arbiter.sv
// Serialises NREQ requesters onto one single-port RAM with range checking.
// Build option: RAM_ARB_RR_EN selects round-robin instead of fixed priority.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NREQ       = RAM_ARB_NREQ,
    parameter int unsigned AW         = RAM_ARB_AW,
    parameter int unsigned DW         = RAM_ARB_DW,
    parameter int unsigned ADDR_LIMIT = RAM_ARB_ADDR_LIMIT
) (
    input  logic                 clk,
    input  logic                 reset,
    ram_access_arbiter_if.slave  bus
);

    localparam int unsigned    IW    = idx_w(NREQ);
    localparam logic [AW:0]    LIMIT = (AW+1)'(ADDR_LIMIT);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;

    logic [NREQ-1:0]  r_grant;
    logic             r_we;
    logic             r_oor;

    logic [NREQ-1:0]  r_ack;
    logic             r_err;
    logic [DW-1:0]    r_rdata;
    logic             r_ram_we;
    logic             r_ram_rd;
    logic [AW-1:0]    r_ram_addr;
    logic [DW-1:0]    r_ram_wdata;

    logic [NREQ-1:0]  w_grant;
    logic [IW-1:0]    w_idx;
    logic             w_valid;
    logic             w_sel_we;
    logic [AW-1:0]    w_sel_addr;
    logic [DW-1:0]    w_sel_wdata;
    logic             w_sel_oor;

    logic             w_latch;
    logic             w_cap_rd;
    logic [NREQ-1:0]  w_ack_nxt;
    logic             w_err_nxt;
    logic             w_ram_we_nxt;
    logic             w_ram_rd_nxt;
    logic [AW-1:0]    w_ram_addr_nxt;
    logic [DW-1:0]    w_ram_wdata_nxt;

`ifdef RAM_ARB_RR_EN
    logic [IW-1:0]    r_ptr;

    ram_arb_pick #(.NREQ(NREQ)) u_pick (
        .i_req     (bus.req),
        .i_ptr     (r_ptr),
        .o_grant_c (w_grant),
        .o_idx_c   (w_idx),
        .o_valid_c (w_valid)
    );

    // Next search starts just past the last winner; only moves on an IDLE grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (r_state == IDLE && w_valid) begin
            r_ptr <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
        end
    end
`else
    ram_arb_pick #(.NREQ(NREQ)) u_pick (
        .i_req     (bus.req),
        .o_grant_c (w_grant),
        .o_idx_c   (w_idx),
        .o_valid_c (w_valid)
    );
`endif

    assign w_sel_we    = bus.we[w_idx];
    assign w_sel_addr  = bus.addr[32'(w_idx)*AW +: AW];
    assign w_sel_wdata = bus.wdata[32'(w_idx)*DW +: DW];
    assign w_sel_oor   = ({1'b0, w_sel_addr} >= LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RAM pins are registered on entry to ACCESS so they are live for exactly that cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_latch         = 1'b0;
        w_cap_rd        = 1'b0;
        w_ack_nxt       = '0;
        w_err_nxt       = 1'b0;
        w_ram_we_nxt    = 1'b0;
        w_ram_rd_nxt    = 1'b0;
        w_ram_addr_nxt  = '0;
        w_ram_wdata_nxt = '0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_nxt = ACCESS;
                    w_latch     = 1'b1;
                    if (!w_sel_oor) begin
                        w_ram_we_nxt   = w_sel_we;
                        w_ram_rd_nxt   = !w_sel_we;
                        w_ram_addr_nxt = w_sel_addr;
                        if (w_sel_we) begin
                            w_ram_wdata_nxt = w_sel_wdata;
                        end
                    end
                end
            end
            ACCESS: begin
                w_state_nxt = RESP;
                w_cap_rd    = !r_oor && !r_we;
                w_ack_nxt   = r_grant;
                w_err_nxt   = r_oor;
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant     <= '0;
            r_we        <= 1'b0;
            r_oor       <= 1'b0;
            r_ack       <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_ram_we    <= 1'b0;
            r_ram_rd    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            if (w_latch) begin
                r_grant <= w_grant;
                r_we    <= w_sel_we;
                r_oor   <= w_sel_oor;
            end
            if (w_cap_rd) begin
                r_rdata <= bus.ram_data_out;
            end
            r_ack       <= w_ack_nxt;
            r_err       <= w_err_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_rd    <= w_ram_rd_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
        end
    end

    assign bus.ack                = r_ack;
    assign bus.err                = r_err;
    assign bus.rdata              = r_rdata;
    assign bus.ram_write_enable   = r_ram_we;
    assign bus.ram_read           = r_ram_rd;
    assign bus.ram_access_address = r_ram_addr;
    assign bus.ram_write_data     = r_ram_wdata;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a small behavioural RAM on the far side.
module tb_ram_access_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 16;

    logic clk;
    logic reset;

    int unsigned n_tests;
    int unsigned n_fail;

    logic [DW-1:0] mem [16];

    ram_access_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    ram_access_arbiter #(
        .NREQ       (NREQ),
        .AW         (AW),
        .DW         (DW),
        .ADDR_LIMIT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_write_enable) begin
            mem[bus.ram_access_address[3:0]] <= bus.ram_write_data;
        end
    end
    assign bus.ram_data_out = mem[bus.ram_access_address[3:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w,
                         input logic [15:0] a1, input logic [15:0] a0,
                         input logic [15:0] d1, input logic [15:0] d0);
        bus.req   = r;
        bus.we    = w;
        bus.addr  = {a1, a0};
        bus.wdata = {d1, d0};
    endtask

    logic [1:0] exp_ack;
    int unsigned ack_cnt;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        cyc();
        cyc();
        reset = 1'b0;

        check("rst_ack",   32'(bus.ack), 32'h0);
        check("rst_err",   32'(bus.err), 32'h0);
        check("rst_rdata", 32'(bus.rdata), 32'h0);
        check("rst_we",    32'(bus.ram_write_enable), 32'h0);
        check("rst_rd",    32'(bus.ram_read), 32'h0);
        check("rst_addr",  32'(bus.ram_access_address), 32'h0);
        check("rst_wdata", 32'(bus.ram_write_data), 32'h0);

        // CPU write 0x0003 <= 0xBEEF
        drive(2'b01, 2'b01, 16'h0, 16'h0003, 16'h0, 16'hBEEF);
        cyc();
        check("wr_we",    32'(bus.ram_write_enable), 32'h1);
        check("wr_addr",  32'(bus.ram_access_address), 32'h3);
        check("wr_wdata", 32'(bus.ram_write_data), 32'hBEEF);
        check("wr_rd",    32'(bus.ram_read), 32'h0);
        check("wr_noack", 32'(bus.ack), 32'h0);
        cyc();
        check("wr_ack",   32'(bus.ack), 32'h1);
        check("wr_err",   32'(bus.err), 32'h0);
        check("wr_we_off", 32'(bus.ram_write_enable), 32'h0);
        check("wr_addr_off", 32'(bus.ram_access_address), 32'h0);
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        cyc();
        check("wr_ack_off", 32'(bus.ack), 32'h0);

        // CPU read 0x0003
        drive(2'b01, 2'b00, 16'h0, 16'h0003, 16'h0, 16'h0);
        cyc();
        check("rd_rd",   32'(bus.ram_read), 32'h1);
        check("rd_we",   32'(bus.ram_write_enable), 32'h0);
        check("rd_addr", 32'(bus.ram_access_address), 32'h3);
        cyc();
        check("rd_ack",   32'(bus.ack), 32'h1);
        check("rd_rdata", 32'(bus.rdata), 32'hBEEF);
        check("rd_rd_off", 32'(bus.ram_read), 32'h0);
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        cyc();

        // DMA read out of range
        drive(2'b10, 2'b00, 16'h0010, 16'h0, 16'h0, 16'h0);
        cyc();
        check("oor_rd", 32'(bus.ram_read), 32'h0);
        check("oor_we", 32'(bus.ram_write_enable), 32'h0);
        cyc();
        check("oor_ack",   32'(bus.ack), 32'h2);
        check("oor_err",   32'(bus.err), 32'h1);
        check("oor_rdata", 32'(bus.rdata), 32'hBEEF);
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        cyc();
        check("oor_err_off", 32'(bus.err), 32'h0);

        // DMA write then read at last legal word 0x000F
        drive(2'b10, 2'b10, 16'h000F, 16'h0, 16'h5A5A, 16'h0);
        cyc();
        check("lim_wr_we",   32'(bus.ram_write_enable), 32'h1);
        check("lim_wr_addr", 32'(bus.ram_access_address), 32'hF);
        cyc();
        check("lim_wr_ack", 32'(bus.ack), 32'h2);
        check("lim_wr_err", 32'(bus.err), 32'h0);
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        cyc();
        drive(2'b10, 2'b00, 16'h000F, 16'h0, 16'h0, 16'h0);
        cyc();
        check("lim_rd_rd", 32'(bus.ram_read), 32'h1);
        cyc();
        check("lim_rd_ack",   32'(bus.ack), 32'h2);
        check("lim_rd_err",   32'(bus.err), 32'h0);
        check("lim_rd_rdata", 32'(bus.rdata), 32'h5A5A);
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        cyc();

        // Both requesters held: CPU reads 0x3, DMA reads 0xF
        drive(2'b11, 2'b00, 16'h000F, 16'h0003, 16'h0, 16'h0);
        for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_RR_EN
            exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_ack = 2'b01;
`endif
            cyc();
            check("arb_strobe", 32'(bus.ram_read), 32'h1);
            check("arb_addr", 32'(bus.ram_access_address),
                  (exp_ack == 2'b01) ? 32'h3 : 32'hF);
            cyc();
            check("arb_ack", 32'(bus.ack), 32'(exp_ack));
            check("arb_rdata", 32'(bus.rdata),
                  (exp_ack == 2'b01) ? 32'hBEEF : 32'h5A5A);
            cyc();
            check("arb_gap", 32'(bus.ack), 32'h0);
        end
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        cyc();
        cyc();

        // Back-to-back CPU reads with req held: one ack every third cycle
        ack_cnt = 0;
        drive(2'b01, 2'b00, 16'h0, 16'h0003, 16'h0, 16'h0);
        for (int c = 1; c <= 9; c++) begin
            cyc();
            if (bus.ack != 2'b00) ack_cnt++;
            check("b2b_ack", 32'(bus.ack), (c % 3 == 2) ? 32'h1 : 32'h0);
        end
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        cyc();
        check("b2b_count", ack_cnt, 32'd3);

        // Reset asserted while the RAM strobe is live
        drive(2'b01, 2'b00, 16'h0, 16'h0003, 16'h0, 16'h0);
        cyc();
        check("mid_rd_pre", 32'(bus.ram_read), 32'h1);
        reset = 1'b1;
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        cyc();
        check("mid_rd",    32'(bus.ram_read), 32'h0);
        check("mid_addr",  32'(bus.ram_access_address), 32'h0);
        check("mid_ack",   32'(bus.ack), 32'h0);
        check("mid_rdata", 32'(bus.rdata), 32'h0);
        reset = 1'b0;
        cyc();
        check("mid_ack2", 32'(bus.ack), 32'h0);
        cyc();
        check("mid_ack3", 32'(bus.ack), 32'h0);
        check("mid_idle", 32'(bus.ram_read), 32'h0);
        drive(2'b01, 2'b01, 16'h0, 16'h0003, 16'h0, 16'h1234);
        cyc();
        check("post_we", 32'(bus.ram_write_enable), 32'h1);
        cyc();
        check("post_ack", 32'(bus.ack), 32'h1);
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
